// File: rtl/dcp_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcp_exec_ctrl_if
// Command channel between the debug command FSM (master) and the execution
// controller (slave).
//   cmd_vld  : command strobe, qualified by cmd_rdy
//   cmd      : 0=STEP, 1=GO, 2=SET_BP, 3=CLR_BP
//   cmd_arg  : breakpoint address for SET_BP/CLR_BP
//   halt     : host abort request for a running GO
//   cmd_rdy  : controller idle, command accepted on cmd_vld & cmd_rdy
//   done     : one-cycle completion pulse
//   status   : 0=OK, 1=BP_HIT, 2=HALTED, 3=ERR, held from done to done
//   running  : GO in progress
//   bp_cnt   : number of valid breakpoint entries
// ---------------------------------------------------------------------------
interface dcp_exec_ctrl_if;
  logic        cmd_vld;
  logic [1:0]  cmd;
  logic [31:0] cmd_arg;
  logic        halt;
  logic        cmd_rdy;
  logic        done;
  logic [1:0]  status;
  logic        running;
  logic [3:0]  bp_cnt;

  modport master (
    output cmd_vld, cmd, cmd_arg, halt,
    input  cmd_rdy, done, status, running, bp_cnt
  );

  modport slave (
    input  cmd_vld, cmd, cmd_arg, halt,
    output cmd_rdy, done, status, running, bp_cnt
  );
endinterface

// File: rtl/dcp_exec_ctrl.sv
// ---------------------------------------------------------------------------
// dcp_exec_ctrl
// Execution controller for the serial debug unit. Generates the gated CPU
// clock, sequences single-step and run-to-breakpoint commands, and owns the
// breakpoint table.
//   clk, rstn : system clock, asynchronous active-low reset
//   cif       : command channel (slave side), see dcp_exec_ctrl_if
//   clk_cpu   : registered CPU clock, high only in the HI phase
//   pc_chk    : CPU is at an instruction boundary
//   npc       : address of the next instruction the CPU will execute
// Parameters: NBP breakpoint entries (1..8), CLK_HALF clk cycles per
// clk_cpu half-period.
// ---------------------------------------------------------------------------
module dcp_exec_ctrl #(
  parameter int NBP      = 4,
  parameter int CLK_HALF = 1
) (
  input  logic            clk,
  input  logic            rstn,
  dcp_exec_ctrl_if.slave  cif,
  output logic            clk_cpu,
  input  logic            pc_chk,
  input  logic [31:0]     npc
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_BPOP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] C_STEP = 2'd0;
  localparam logic [1:0] C_GO   = 2'd1;
  localparam logic [1:0] C_SET  = 2'd2;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BPHIT  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int IW = (NBP > 1) ? $clog2(NBP) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);

  logic [2:0]     state;
  logic [CW-1:0]  cnt;
  logic [1:0]     cmd_q;
  logic [31:0]    arg_q;
  logic [1:0]     status_q;
  logic [NBP-1:0] bp_vld;
  logic [31:0]    bp_addr [NBP];

  logic           hit;
  logic           match_any;
  logic [IW-1:0]  match_idx;
  logic           free_any;
  logic [IW-1:0]  free_idx;
  logic [NBP-1:0] bp_vld_nxt;
  logic           bp_wr;
  logic [1:0]     bp_status;
  logic [3:0]     cnt_valid;

  // Table lookups. The loop runs from the top index down so the lowest
  // matching / free index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NBP - 1; i >= 0; i--) begin
      if (bp_vld[i] && (bp_addr[i] == npc)) hit = 1'b1;
      if (bp_vld[i] && (bp_addr[i] == arg_q)) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
      if (!bp_vld[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Outcome of a SET_BP/CLR_BP, applied in the single BPOP cycle.
  // An existing match takes precedence over the full check on SET_BP.
  always_comb begin
    bp_vld_nxt = bp_vld;
    bp_wr      = 1'b0;
    bp_status  = ST_OK;
    if (cmd_q == C_SET) begin
      if (!match_any) begin
        if (free_any) begin
          bp_wr                = 1'b1;
          bp_vld_nxt[free_idx] = 1'b1;
        end else begin
          bp_status = ST_ERR;
        end
      end
    end else begin
      if (arg_q == 32'hFFFF_FFFF) begin
        bp_vld_nxt = '0;
      end else if (match_any) begin
        bp_vld_nxt[match_idx] = 1'b0;
      end else begin
        bp_status = ST_ERR;
      end
    end
  end

  always_comb begin
    cnt_valid = '0;
    for (int i = 0; i < NBP; i++) cnt_valid = cnt_valid + 4'(bp_vld[i]);
  end

  // Main sequencer. clk_cpu is registered alongside the state so that it
  // is high exactly while the state is HI and falls with an async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cmd_q    <= C_STEP;
      arg_q    <= '0;
      status_q <= ST_OK;
      clk_cpu  <= 1'b0;
      bp_vld   <= '0;
      for (int i = 0; i < NBP; i++) bp_addr[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cif.cmd_vld) begin
            cmd_q <= cif.cmd;
            arg_q <= cif.cmd_arg;
            if (cif.cmd[1]) begin
              state <= S_BPOP;
            end else begin
              state   <= S_HI;
              clk_cpu <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            state   <= S_LO;
            clk_cpu <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LO: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= S_CHK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHK: begin
          // Unretired instruction, step done, breakpoint, halt, continue.
          if (!pc_chk) begin
            state   <= S_HI;
            clk_cpu <= 1'b1;
          end else if (cmd_q == C_STEP) begin
            state    <= S_DONE;
            status_q <= ST_OK;
          end else if (hit) begin
            state    <= S_DONE;
            status_q <= ST_BPHIT;
          end else if (cif.halt) begin
            state    <= S_DONE;
            status_q <= ST_HALTED;
          end else begin
            state   <= S_HI;
            clk_cpu <= 1'b1;
          end
        end
        S_BPOP: begin
          bp_vld   <= bp_vld_nxt;
          status_q <= bp_status;
          if (bp_wr) bp_addr[free_idx] <= arg_q;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          clk_cpu <= 1'b0;
        end
      endcase
    end
  end

  assign cif.cmd_rdy = (state == S_IDLE);
  assign cif.done    = (state == S_DONE);
  assign cif.status  = status_q;
  assign cif.bp_cnt  = cnt_valid;
  assign cif.running = (cmd_q == C_GO) &&
                       ((state == S_HI) || (state == S_LO) || (state == S_CHK));

endmodule
